// File: rtl/ctrl_decode_stage_if.sv
// ctrl_decode_stage_if: fetch-side and execute-side bundle signals of the decode stage.
interface ctrl_decode_stage_if #(
   parameter int LANES = 1,
   parameter int CNT_W = 16
);
   logic                  in_valid;
   logic                  in_ready;
   logic [32*LANES-1:0]   instr;
   logic                  flush;
   logic                  out_valid;
   logic                  out_ready;
   logic [LANES-1:0]      lane_valid;
   logic [16*LANES-1:0]   ctrl;
   logic [CNT_W-1:0]      illegal_count;
   modport master (
      output in_valid, instr, flush, out_ready,
      input  in_ready, out_valid, lane_valid, ctrl, illegal_count
   );
   modport slave (
      input  in_valid, instr, flush, out_ready,
      output in_ready, out_valid, lane_valid, ctrl, illegal_count
   );
endinterface

// File: rtl/ctrl_decode_stage.sv
// ctrl_decode_stage: registered multi-lane RV32I control decoder with skid entry and illegal-lane kill.
// Define ZICSR_EN to accept Zicsr instructions (opcode 1110011, funct3 != 000/100).
module ctrl_decode_stage #(
   parameter int LANES = 1,
   parameter int CNT_W = 16
) (
   input logic               clk,
   input logic               reset,
   ctrl_decode_stage_if.slave bus
);
   // Word layout: illegal,RegWrite,ImmSrc[3],ALUSrc,MemWrite,ResultSrc[2],Branch,ALUOp[2],Jump,SrcAsrc,jumpReg,csr
   function automatic logic [15:0] dec(input logic [31:0] i);
      logic [6:0] op;
      logic [2:0] f3;
      logic [6:0] f7;
      op  = i[6:0];
      f3  = i[14:12];
      f7  = i[31:25];
      dec = 16'h8000;
      case (op)
         7'b0000011: if (f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) dec = 16'b0_1_000_1_0_01_0_00_0_0_1_0;
         7'b0100011: if (f3 inside {3'b000, 3'b001, 3'b010}) dec = 16'b0_0_001_1_1_00_0_00_0_0_1_0;
         7'b0110011: if (f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'b000 || f3 == 3'b101)))
            dec = 16'b0_1_000_0_0_00_0_10_0_0_1_0;
         7'b0010011: if (f3 == 3'b001 ? f7 == 7'h00 : f3 == 3'b101 ? (f7 == 7'h00 || f7 == 7'h20) : 1'b1)
            dec = 16'b0_1_000_1_0_00_0_10_0_0_1_0;
         7'b1100011: if (f3 != 3'b010 && f3 != 3'b011) dec = 16'b0_0_010_0_0_00_1_01_0_0_1_0;
         7'b0110111: dec = 16'b0_1_100_1_0_11_0_00_0_0_1_0;
         7'b0010111: dec = 16'b0_1_100_1_0_00_0_00_0_1_1_0;
         7'b1101111: dec = 16'b0_1_011_0_0_10_0_00_1_1_1_0;
         7'b1100111: if (f3 == 3'b000) dec = 16'b0_1_000_0_0_10_0_00_1_0_0_0;
`ifdef ZICSR_EN
         7'b1110011: if (f3 != 3'b000 && f3 != 3'b100) dec = 16'b0_1_000_0_0_00_0_00_0_0_1_1;
`endif
         default: dec = 16'h8000;
      endcase
   endfunction

   logic [LANES-1:0]    new_lv;
   logic [16*LANES-1:0] new_ctrl;
   logic                new_ill;

   // Lanes after the oldest illegal one are killed; the illegal lane itself stays live.
   always_comb begin
      new_ill  = 1'b0;
      new_lv   = '0;
      new_ctrl = '0;
      for (int l = 0; l < LANES; l++) begin
         if (!new_ill) begin
            new_lv[l]            = 1'b1;
            new_ctrl[16*l +: 16] = dec(bus.instr[32*l +: 32]);
            new_ill              = new_ctrl[16*l+15];
         end
      end
   end

   logic                out_v_q, out_v_d;
   logic [LANES-1:0]    out_lv_q, out_lv_d;
   logic [16*LANES-1:0] out_ctrl_q, out_ctrl_d;
   logic                skid_v_q, skid_v_d;
   logic [LANES-1:0]    skid_lv_q, skid_lv_d;
   logic [16*LANES-1:0] skid_ctrl_q, skid_ctrl_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                acc, take;

   assign acc  = bus.in_valid && !skid_v_q;
   assign take = !out_v_q || bus.out_ready;

   // Skid entry is only ever filled while it is empty, so skid refill and accept never collide.
   always_comb begin
      out_v_d     = out_v_q;
      out_lv_d    = out_lv_q;
      out_ctrl_d  = out_ctrl_q;
      skid_v_d    = skid_v_q;
      skid_lv_d   = skid_lv_q;
      skid_ctrl_d = skid_ctrl_q;
      if (bus.flush) begin
         out_v_d  = 1'b0;
         skid_v_d = 1'b0;
      end else if (take) begin
         out_v_d    = skid_v_q || acc;
         out_lv_d   = skid_v_q ? skid_lv_q : new_lv;
         out_ctrl_d = skid_v_q ? skid_ctrl_q : new_ctrl;
         skid_v_d   = 1'b0;
      end else if (acc) begin
         skid_v_d    = 1'b1;
         skid_lv_d   = new_lv;
         skid_ctrl_d = new_ctrl;
      end
      cnt_d = (acc && !bus.flush && new_ill && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_v_q     <= 1'b0;
         out_lv_q    <= '0;
         out_ctrl_q  <= '0;
         skid_v_q    <= 1'b0;
         skid_lv_q   <= '0;
         skid_ctrl_q <= '0;
         cnt_q       <= '0;
      end else begin
         out_v_q     <= out_v_d;
         out_lv_q    <= out_lv_d;
         out_ctrl_q  <= out_ctrl_d;
         skid_v_q    <= skid_v_d;
         skid_lv_q   <= skid_lv_d;
         skid_ctrl_q <= skid_ctrl_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_ready      = !skid_v_q;
   assign bus.out_valid     = out_v_q;
   assign bus.lane_valid    = out_v_q ? out_lv_q : '0;
   assign bus.ctrl          = out_v_q ? out_ctrl_q : '0;
   assign bus.illegal_count = cnt_q;
endmodule

// File: tb/tb_ctrl_decode_stage.sv
// tb_ctrl_decode_stage: directed scenarios plus randomized traffic against a queue-based reference model.
module tb_ctrl_decode_stage;
   localparam int LANES = 2;
   localparam int CNT_W = 4;

   typedef struct packed {
      logic [LANES-1:0]    lv;
      logic [16*LANES-1:0] c;
   } bundle_t;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   fails = 0;

   always #5 clk = ~clk;

   ctrl_decode_stage_if #(.LANES(LANES), .CNT_W(CNT_W)) bus ();
   ctrl_decode_stage #(.LANES(LANES), .CNT_W(CNT_W)) dut (.clk(clk), .reset(reset), .bus(bus));

   // Reference decode built from named fields rather than whole-word constants.
   function automatic logic [15:0] ref_dec(input logic [31:0] i);
      logic [6:0] op, f7;
      logic [2:0] f3, imm;
      logic [1:0] rs, aop;
      logic       legal, rw, as, mw, br, j, sa, jr, cs;
      op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
      legal = 0; rw = 0; imm = 0; as = 0; mw = 0; rs = 0; br = 0; aop = 0; j = 0; sa = 0; jr = 1; cs = 0;
      if (op == 7'b0000011) begin
         legal = (f3 <= 2) || f3 == 4 || f3 == 5; rw = 1; as = 1; rs = 1;
      end else if (op == 7'b0100011) begin
         legal = f3 <= 2; imm = 1; as = 1; mw = 1;
      end else if (op == 7'b0110011) begin
         legal = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); rw = 1; aop = 2;
      end else if (op == 7'b0010011) begin
         if (f3 == 1) legal = f7 == 0;
         else if (f3 == 5) legal = f7 == 0 || f7 == 7'h20;
         else legal = 1;
         rw = 1; as = 1; aop = 2;
      end else if (op == 7'b1100011) begin
         legal = f3 != 2 && f3 != 3; imm = 2; br = 1; aop = 1;
      end else if (op == 7'b0110111) begin
         legal = 1; rw = 1; imm = 4; as = 1; rs = 3;
      end else if (op == 7'b0010111) begin
         legal = 1; rw = 1; imm = 4; as = 1; sa = 1;
      end else if (op == 7'b1101111) begin
         legal = 1; rw = 1; imm = 3; rs = 2; j = 1; sa = 1;
      end else if (op == 7'b1100111) begin
         legal = f3 == 0; rw = 1; rs = 2; j = 1; jr = 0;
      end else if (op == 7'b1110011) begin
`ifdef ZICSR_EN
         legal = f3 != 0 && f3 != 4; rw = 1; cs = 1;
`else
         legal = 0;
`endif
      end
      return legal ? {1'b0, rw, imm, as, mw, rs, br, aop, j, sa, jr, cs} : 16'h8000;
   endfunction

   function automatic bundle_t ref_bundle(input logic [32*LANES-1:0] ins);
      bundle_t b;
      int k;
      k = LANES;
      for (int l = LANES - 1; l >= 0; l--)
         if (ref_dec(ins[32*l +: 32]) == 16'h8000) k = l;
      b = '0;
      for (int l = 0; l < LANES; l++)
         if (l <= k) begin
            b.lv[l] = 1'b1;
            b.c[16*l +: 16] = ref_dec(ins[32*l +: 32]);
         end
      return b;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0] ops [10];
      logic [31:0] r;
      ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
              7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1110011};
      r = $urandom;
      if ($urandom_range(0, 11) < 10) r[6:0] = ops[$urandom_range(0, 9)];
      case ($urandom_range(0, 2))
         0: r[31:25] = 7'h00;
         1: r[31:25] = 7'h20;
         default: ;
      endcase
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
      bus.out_ready = 1'b0;
      bus.instr = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset out_valid got %b want 0", bus.out_valid); end
      checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset in_ready got %b want 1", bus.in_ready); end
      checks++; if (bus.lane_valid !== '0) begin fails++; $display("FAIL reset lane_valid got %b want 0", bus.lane_valid); end
      checks++; if (bus.ctrl !== '0) begin fails++; $display("FAIL reset ctrl got %h want 0", bus.ctrl); end
      checks++; if (bus.illegal_count !== '0) begin fails++; $display("FAIL reset count got %0d want 0", bus.illegal_count); end
   endtask

   task automatic test_decode();
      do_reset();
      bus.in_valid = 1'b1;
      bus.instr = {32'h006282B3, 32'h00A28293};
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL decode out_valid got %b want 1", bus.out_valid); end
      checks++; if (bus.ctrl !== {16'h4022, 16'h4422}) begin fails++; $display("FAIL decode ctrl got %h want 40224422", bus.ctrl); end
      checks++; if (bus.lane_valid !== 2'b11) begin fails++; $display("FAIL decode lane_valid got %b want 11", bus.lane_valid); end
      repeat (2) tick();
      checks++; if (bus.ctrl !== {16'h4022, 16'h4422} || bus.out_valid !== 1'b1) begin fails++; $display("FAIL decode hold ctrl got %h want 40224422", bus.ctrl); end
      bus.out_ready = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL decode drain out_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_kill();
      do_reset();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.instr = {32'hFFFFFFFF, 32'h0000006F};
      tick();
      checks++; if (bus.ctrl !== {16'h8000, 16'h590E}) begin fails++; $display("FAIL kill_last ctrl got %h want 8000590e", bus.ctrl); end
      checks++; if (bus.lane_valid !== 2'b11) begin fails++; $display("FAIL kill_last lane_valid got %b want 11", bus.lane_valid); end
      checks++; if (bus.illegal_count !== 4'd1) begin fails++; $display("FAIL kill_last count got %0d want 1", bus.illegal_count); end
      bus.instr = {32'h00A28293, 32'h00000000};
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.ctrl !== {16'h0000, 16'h8000}) begin fails++; $display("FAIL kill_first ctrl got %h want 00008000", bus.ctrl); end
      checks++; if (bus.lane_valid !== 2'b01) begin fails++; $display("FAIL kill_first lane_valid got %b want 01", bus.lane_valid); end
      checks++; if (bus.illegal_count !== 4'd2) begin fails++; $display("FAIL kill_first count got %0d want 2", bus.illegal_count); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      bus.in_valid = 1'b1;
      bus.instr = {32'h00502023, 32'h000012B7};
      checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp c0 in_ready got %b want 1", bus.in_ready); end
      tick();
      checks++; if (bus.in_ready !== 1'b1 || bus.ctrl !== {16'h0E02, 16'h6582}) begin fails++; $display("FAIL bp c1 in_ready %b ctrl %h want 1 0e026582", bus.in_ready, bus.ctrl); end
      bus.instr = {32'h00008067, 32'h00000063};
      tick();
      checks++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp c2 in_ready got %b want 0", bus.in_ready); end
      bus.instr = {32'h006282B3, 32'h00A28293};
      tick();
      checks++; if (bus.in_ready !== 1'b0 || bus.ctrl !== {16'h0E02, 16'h6582}) begin fails++; $display("FAIL bp c3 in_ready %b ctrl %h want 0 0e026582", bus.in_ready, bus.ctrl); end
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      tick();
      checks++; if (bus.out_valid !== 1'b1 || bus.ctrl !== {16'h4108, 16'h1052}) begin fails++; $display("FAIL bp second ctrl got %h want 41081052", bus.ctrl); end
      checks++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp release in_ready got %b want 1", bus.in_ready); end
      tick();
      checks++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp third out_valid got %b want 0", bus.out_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      bus.in_valid = 1'b1;
      bus.instr = {32'h00502023, 32'h000012B7};
      repeat (2) tick();
      bus.instr = {32'hFFFFFFFF, 32'hFFFFFFFF};
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      bus.in_valid = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL flush_full out_valid %b in_ready %b want 0 1", bus.out_valid, bus.in_ready); end
      checks++; if (bus.illegal_count !== 4'd0) begin fails++; $display("FAIL flush_full count got %0d want 0", bus.illegal_count); end
      bus.in_valid = 1'b1;
      bus.instr = {32'h00502023, 32'h000012B7};
      tick();
      bus.instr = {32'hFFFFFFFF, 32'hFFFFFFFF};
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      checks++; if (bus.out_valid !== 1'b0 || bus.illegal_count !== 4'd0) begin fails++; $display("FAIL flush_accept out_valid %b count %0d want 0 0", bus.out_valid, bus.illegal_count); end
      bus.out_ready = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.ctrl !== {16'h0000, 16'h8000} || bus.illegal_count !== 4'd1) begin fails++; $display("FAIL flush_after ctrl %h count %0d want 00008000 1", bus.ctrl, bus.illegal_count); end
   endtask

   task automatic test_csr();
      do_reset();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.instr = {32'h00A28293, 32'h30002573};
      tick();
`ifdef ZICSR_EN
      checks++; if (bus.ctrl !== {16'h4422, 16'h4003} || bus.lane_valid !== 2'b11) begin fails++; $display("FAIL csrrs ctrl %h lv %b want 44224003 11", bus.ctrl, bus.lane_valid); end
`else
      checks++; if (bus.ctrl !== {16'h0000, 16'h8000} || bus.lane_valid !== 2'b01) begin fails++; $display("FAIL csrrs ctrl %h lv %b want 00008000 01", bus.ctrl, bus.lane_valid); end
`endif
      bus.instr = {32'h00A28293, 32'h00000073};
      tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.ctrl !== {16'h0000, 16'h8000} || bus.lane_valid !== 2'b01) begin fails++; $display("FAIL ecall ctrl %h lv %b want 00008000 01", bus.ctrl, bus.lane_valid); end
   endtask

   task automatic test_saturation();
      do_reset();
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.instr = {32'h00A28293, 32'hFFFFFFFF};
      repeat (14) tick();
      checks++; if (bus.illegal_count !== 4'd14) begin fails++; $display("FAIL sat_14 count got %0d want 14", bus.illegal_count); end
      repeat (5) tick();
      bus.in_valid = 1'b0;
      checks++; if (bus.illegal_count !== 4'd15) begin fails++; $display("FAIL sat_max count got %0d want 15", bus.illegal_count); end
   endtask

   task automatic test_random();
      bundle_t q[$];
      bundle_t exp;
      int      mcnt;
      logic    acc;
      do_reset();
      mcnt = 0;
      for (int n = 0; n < 3000; n++) begin
         bus.in_valid  = $urandom_range(0, 3) != 0;
         bus.out_ready = $urandom_range(0, 2) != 0;
         bus.flush     = $urandom_range(0, 23) == 0;
         bus.instr     = {rand_instr(), rand_instr()};
         @(negedge clk);
         exp = (q.size() > 0) ? q[0] : '0;
         checks++; if (bus.out_valid !== (q.size() > 0)) begin fails++; $display("FAIL rnd out_valid cyc %0d got %b want %b", n, bus.out_valid, q.size() > 0); end
         checks++; if (bus.in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rnd in_ready cyc %0d got %b want %b", n, bus.in_ready, q.size() < 2); end
         checks++; if (bus.lane_valid !== exp.lv || bus.ctrl !== exp.c) begin fails++; $display("FAIL rnd data cyc %0d got %b/%h want %b/%h", n, bus.lane_valid, bus.ctrl, exp.lv, exp.c); end
         checks++; if (bus.illegal_count !== CNT_W'(mcnt)) begin fails++; $display("FAIL rnd count cyc %0d got %0d want %0d", n, bus.illegal_count, mcnt); end
         @(posedge clk);
         acc = bus.in_valid && q.size() < 2;
         if (bus.flush) q.delete();
         else begin
            if (bus.out_ready && q.size() > 0) void'(q.pop_front());
            if (acc) begin
               q.push_back(ref_bundle(bus.instr));
               if (|ref_bundle(bus.instr).c) begin
                  for (int l = 0; l < LANES; l++)
                     if (ref_dec(bus.instr[32*l +: 32]) == 16'h8000) begin
                        if (mcnt < 15) mcnt++;
                        break;
                     end
               end else begin
                  for (int l = 0; l < LANES; l++)
                     if (ref_dec(bus.instr[32*l +: 32]) == 16'h8000) begin
                        if (mcnt < 15) mcnt++;
                        break;
                     end
               end
            end
         end
         #1;
      end
      bus.in_valid = 1'b0;
      bus.flush = 1'b0;
   endtask

   initial begin
      test_reset();
      test_decode();
      test_kill();
      test_back_to_back();
      test_flush();
      test_csr();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
